// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI read-channel arbiter.
package axi_arb_pkg;

  localparam int NUM_REQ = 2;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_pick2.sv
// Combinational winner select between fetch (0) and data load (1).
// ARB_ROUND_ROBIN_EN defined: ties alternate away from last_grant; otherwise data load has fixed priority.
module arb_pick2
  import axi_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               last_grant,
  output logic               win
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    if (&req_valid) win = ~last_grant;
    else            win = req_valid[REQ_DATA];
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // A lone fetch request still wins because req_valid[REQ_DATA] is then 0.
  always_comb begin
    win = req_valid[REQ_DATA];
  end
`endif

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel (AR/R) between fetch and data load, one burst outstanding at a time.
// Arbitration policy selected by ARB_ROUND_ROBIN_EN (see arb_pick2).
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]             req_len,
  input  logic [5:0]              req_size,
  output logic [1:0]              req_ready,
  output logic [1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    resp_last,
  output logic                    resp_err,
  input  logic [1:0]              resp_ready,
  output logic                    busy,
  output logic                    proto_err,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  arb_state_e            state;
  logic                  grant;
  logic                  last_grant;
  logic [7:0]            count;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic                  win;
  logic                  accept;
  logic                  r_fire;
  logic                  rid_bad;
  logic                  last_bad;
  logic [ID_WIDTH-1:0]   grant_id;

  arb_pick2 u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .win        (win)
  );

  assign accept   = (state == IDLE) && (|req_valid);
  assign grant_id = {{(ID_WIDTH-1){1'b0}}, grant};
  assign r_fire   = (state == DATA) && m_axi_rvalid && m_axi_rready;
  assign rid_bad  = (m_axi_rid != grant_id);
  assign last_bad = (m_axi_rlast != (count == len_q));

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (state == DATA) resp_valid[grant] = m_axi_rvalid;
  end

  assign resp_data    = m_axi_rdata;
  assign resp_last    = (state == DATA) && m_axi_rvalid && m_axi_rlast;
  assign resp_err     = (state == DATA) && m_axi_rvalid && (m_axi_rresp != AXI_RESP_OKAY);
  assign m_axi_rready = (state == DATA) && resp_ready[grant];
  assign busy         = (state != IDLE);

  assign m_axi_arvalid = (state == ADDR);
  assign m_axi_arid    = m_axi_arvalid ? grant_id : '0;
  assign m_axi_araddr  = m_axi_arvalid ? addr_q   : '0;
  assign m_axi_arlen   = m_axi_arvalid ? len_q    : '0;
  assign m_axi_arsize  = m_axi_arvalid ? size_q   : '0;
  assign m_axi_arburst = AXI_BURST_INCR;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= REQ_FETCH;
      last_grant <= REQ_FETCH;
      count      <= '0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant <= win;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            count <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (r_fire) begin
            count <= count + 8'd1;
            if (rid_bad || last_bad) proto_err <= 1'b1;
            // Exit follows the slave's RLAST even when it disagrees with our count.
            if (m_axi_rlast) begin
              last_grant <= grant;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: request fields are only observed while in ADDR, after being loaded, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
      len_q  <= win ? req_len[15:8]  : req_len[7:0];
      size_q <= win ? req_size[5:3]  : req_size[2:0];
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter; expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_axi_read_arbiter;

  localparam int IDW = 13;
  localparam int AW  = 64;
  localparam int DW  = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [2*AW-1:0] req_addr;
  logic [15:0]     req_len;
  logic [5:0]      req_size;
  logic [1:0]      req_ready;
  logic [1:0]      resp_valid;
  logic [DW-1:0]   resp_data;
  logic            resp_last;
  logic            resp_err;
  logic [1:0]      resp_ready;
  logic            busy;
  logic            proto_err;
  logic [IDW-1:0]  m_axi_arid;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic            m_axi_arvalid;
  logic            m_axi_arready;
  logic [IDW-1:0]  m_axi_rid;
  logic [DW-1:0]   m_axi_rdata;
  logic [1:0]      m_axi_rresp;
  logic            m_axi_rlast;
  logic            m_axi_rvalid;
  logic            m_axi_rready;

  int   errors = 0;
  int   checks = 0;
  logic exp_lg;

  always #5 clk = ~clk;

  axi_read_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .req_size      (req_size),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_last     (resp_last),
    .resp_err      (resp_err),
    .resp_ready    (resp_ready),
    .busy          (busy),
    .proto_err     (proto_err),
    .m_axi_arid    (m_axi_arid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rid     (m_axi_rid),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size);
    req_addr[idx*AW +: AW] = addr;
    req_len[idx*8 +: 8]    = len;
    req_size[idx*3 +: 3]   = size;
    req_valid[idx]         = 1'b1;
  endtask

  // Called in IDLE with requests driven; checks the accept pulse, then leaves req_valid = keep.
  task automatic accept(input string name, input logic [1:0] exp_ready, input logic [1:0] keep);
    #1;
    checks++;
    if (req_ready !== exp_ready) begin
      errors++;
      $display("FAIL %s req_ready: got %b want %b", name, req_ready, exp_ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_busy: got %b want 0", name, busy);
    end
    step;
    req_valid = keep;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL %s no_accept_in_addr: got %b want 00", name, req_ready);
    end
  endtask

  // Called in ADDR; checks AR fields, holds them over one stalled cycle, then handshakes.
  task automatic addr_phase(input string name, input logic id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (m_axi_arvalid !== 1'b1 || m_axi_arid !== {12'b0, id} || m_axi_araddr !== addr ||
          m_axi_arlen !== len || m_axi_arsize !== size || m_axi_arburst !== 2'b01 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s ar_fields[%0d]: got v=%b id=%0d a=%h l=%0d s=%0d b=%b want v=1 id=%0d a=%h l=%0d s=%0d b=01",
                 name, c, m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
                 m_axi_arburst, id, addr, len, size);
      end
      if (c == 0) step;
    end
    m_axi_arready = 1'b1;
    step;
    m_axi_arready = 1'b0;
    checks++;
    if (m_axi_arvalid !== 1'b0 || m_axi_arid !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s ar_after_hs: got v=%b id=%0d busy=%b want v=0 id=0 busy=1",
               name, m_axi_arvalid, m_axi_arid, busy);
    end
  endtask

  // Drives n beats numbered first..first+n-1; rlast on index last_at, error response on err_at.
  task automatic beats(input string name, input logic g, input logic id, input int first,
                       input int n, input int last_at, input int err_at, input logic [DW-1:0] base);
    logic [1:0] exp_v;
    exp_v = g ? 2'b10 : 2'b01;
    for (int i = first; i < first + n; i++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rid    = {12'b0, id};
      m_axi_rdata  = base + DW'(i);
      m_axi_rlast  = (i == last_at);
      m_axi_rresp  = (i == err_at) ? 2'b10 : 2'b00;
      resp_ready   = exp_v;
      #1;
      checks++;
      if (resp_valid !== exp_v || resp_data !== base + DW'(i) || resp_last !== (i == last_at) ||
          resp_err !== (i == err_at) || m_axi_rready !== 1'b1) begin
        errors++;
        $display("FAIL %s beat%0d: got v=%b d=%h last=%b err=%b rr=%b want v=%b d=%h last=%b err=%b rr=1",
                 name, i, resp_valid, resp_data, resp_last, resp_err, m_axi_rready,
                 exp_v, base + DW'(i), (i == last_at), (i == err_at));
      end
      step;
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'b00;
    resp_ready   = 2'b00;
  endtask

  task automatic check_end(input string name, input logic exp_busy, input logic exp_perr);
    #1;
    checks++;
    if (busy !== exp_busy || proto_err !== exp_perr || m_axi_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s end_state: got busy=%b perr=%b arv=%b want busy=%b perr=%b arv=0",
               name, busy, proto_err, m_axi_arvalid, exp_busy, exp_perr);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = '0; req_addr = '0; req_len = '0; req_size = '0; resp_ready = '0;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    step; step;
    reset = 1'b0;
    step;
    checks++;
    if (busy !== 1'b0 || proto_err !== 1'b0 || req_ready !== 2'b00 || resp_valid !== 2'b00 ||
        m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 || m_axi_araddr !== '0 ||
        m_axi_arburst !== 2'b01 || resp_last !== 1'b0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b perr=%b rq=%b rv=%b arv=%b rr=%b burst=%b want 0,0,00,00,0,0,01",
               busy, proto_err, req_ready, resp_valid, m_axi_arvalid, m_axi_rready, m_axi_arburst);
    end
    exp_lg = 1'b0;
  endtask

  task automatic test_fetch_only;
    set_req(0, 64'h8000_0000, 8'd3, 3'd3);
    accept("fetch_only", 2'b01, 2'b00);
    addr_phase("fetch_only", 1'b0, 64'h8000_0000, 8'd3, 3'd3);
    beats("fetch_only", 1'b0, 1'b0, 0, 4, 3, -1, 64'hF000_0000);
    check_end("fetch_only", 1'b0, 1'b0);
    exp_lg = 1'b0;
  endtask

  task automatic test_back_to_back;
    set_req(1, 64'h1000, 8'd1, 3'd3);
    set_req(0, 64'h2000, 8'd0, 3'd2);
    // last_grant = 0, so both builds hand the tie to data load.
    accept("b2b_data", 2'b10, 2'b01);
    addr_phase("b2b_data", 1'b1, 64'h1000, 8'd1, 3'd3);
    beats("b2b_data", 1'b1, 1'b1, 0, 2, 1, -1, 64'hD000_0000);
    accept("b2b_fetch", 2'b01, 2'b00);
    addr_phase("b2b_fetch", 1'b0, 64'h2000, 8'd0, 3'd2);
    beats("b2b_fetch", 1'b0, 1'b0, 0, 1, 0, -1, 64'hE000_0000);
    check_end("b2b", 1'b0, 1'b0);
    exp_lg = 1'b0;
  endtask

  task automatic test_contention;
    logic w;
    set_req(1, 64'h3000, 8'd0, 3'd3);
    accept("cont_prime", 2'b10, 2'b00);
    addr_phase("cont_prime", 1'b1, 64'h3000, 8'd0, 3'd3);
    beats("cont_prime", 1'b1, 1'b1, 0, 1, 0, -1, 64'hA000);
    exp_lg = 1'b1;
    set_req(0, 64'h4000, 8'd0, 3'd1);
    set_req(1, 64'h5000, 8'd0, 3'd3);
    for (int r = 0; r < 3; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
      w = ~exp_lg;
`else
      w = 1'b1;
`endif
      accept($sformatf("cont_r%0d", r), w ? 2'b10 : 2'b01, 2'b11);
      addr_phase($sformatf("cont_r%0d", r), w, w ? 64'h5000 : 64'h4000, 8'd0, w ? 3'd3 : 3'd1);
      beats($sformatf("cont_r%0d", r), w, w, 0, 1, 0, -1, 64'hB000 + DW'(r));
      exp_lg = w;
    end
    req_valid = 2'b00;
    check_end("contention", 1'b0, 1'b0);
  endtask

  task automatic test_stall;
    set_req(1, 64'h6000, 8'd3, 3'd3);
    accept("stall", 2'b10, 2'b00);
    addr_phase("stall", 1'b1, 64'h6000, 8'd3, 3'd3);
    beats("stall", 1'b1, 1'b1, 0, 1, -1, -1, 64'hC000);
    m_axi_rvalid = 1'b1; m_axi_rid = 13'd1; m_axi_rdata = 64'hC001; m_axi_rlast = 1'b0;
    resp_ready = 2'b00;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (m_axi_rready !== 1'b0 || resp_valid !== 2'b10 || resp_data !== 64'hC001 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: got rr=%b rv=%b d=%h busy=%b want rr=0 rv=10 d=c001 busy=1",
                 c, m_axi_rready, resp_valid, resp_data, busy);
      end
      step;
    end
    beats("stall", 1'b1, 1'b1, 1, 3, 3, 2, 64'hC000);
    check_end("stall", 1'b0, 1'b0);
    exp_lg = 1'b1;
  endtask

  task automatic test_long_burst;
    set_req(1, 64'h7000, 8'd255, 3'd3);
    accept("long", 2'b10, 2'b00);
    addr_phase("long", 1'b1, 64'h7000, 8'd255, 3'd3);
    beats("long", 1'b1, 1'b1, 0, 256, 255, -1, 64'h1_0000);
    check_end("long", 1'b0, 1'b0);
    exp_lg = 1'b1;
  endtask

  task automatic test_proto_rlast;
    set_req(0, 64'h8000, 8'd3, 3'd3);
    accept("early_last", 2'b01, 2'b00);
    addr_phase("early_last", 1'b0, 64'h8000, 8'd3, 3'd3);
    beats("early_last", 1'b0, 1'b0, 0, 2, 1, -1, 64'h2_0000);
    check_end("early_last", 1'b0, 1'b1);
    set_req(0, 64'h8100, 8'd0, 3'd3);
    accept("sticky", 2'b01, 2'b00);
    addr_phase("sticky", 1'b0, 64'h8100, 8'd0, 3'd3);
    beats("sticky", 1'b0, 1'b0, 0, 1, 0, -1, 64'h3_0000);
    check_end("sticky", 1'b0, 1'b1);
    exp_lg = 1'b0;
  endtask

  task automatic test_reset_mid_burst;
    set_req(1, 64'h9000, 8'd3, 3'd3);
    accept("rst_mid", 2'b10, 2'b00);
    addr_phase("rst_mid", 1'b1, 64'h9000, 8'd3, 3'd3);
    beats("rst_mid", 1'b1, 1'b1, 0, 1, -1, -1, 64'h4_0000);
    m_axi_rvalid = 1'b1; m_axi_rid = 13'd1; m_axi_rdata = 64'h4_0001; m_axi_rlast = 1'b1;
    m_axi_rresp = 2'b10; resp_ready = 2'b10;
    reset = 1'b1;
    step;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (busy !== 1'b0 || proto_err !== 1'b0 || m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 ||
          resp_valid !== 2'b00 || resp_last !== 1'b0 || resp_err !== 1'b0 || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL rst_mid_idle%0d: got busy=%b perr=%b arv=%b rr=%b rv=%b rl=%b re=%b rq=%b want all 0",
                 c, busy, proto_err, m_axi_arvalid, m_axi_rready, resp_valid, resp_last, resp_err, req_ready);
      end
      step;
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; resp_ready = 2'b00;
    exp_lg = 1'b0;
    // Fresh fetch burst after reset; the slave answers with the wrong RID.
    set_req(0, 64'hA000, 8'd1, 3'd2);
    accept("post_rst", 2'b01, 2'b00);
    addr_phase("post_rst", 1'b0, 64'hA000, 8'd1, 3'd2);
    beats("post_rst", 1'b0, 1'b1, 0, 2, 1, -1, 64'h5_0000);
    check_end("bad_rid", 1'b0, 1'b1);
  endtask

  initial begin
    fork
      begin
        test_reset;
        test_fetch_only;
        test_back_to_back;
        test_contention;
        test_stall;
        test_long_burst;
        test_proto_rlast;
        test_reset_mid_burst;
      end
      begin
        #200000;
        errors++;
        $display("FAIL timeout: got no completion want completion within 200000 time units");
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
